// File: rtl/muldiv_unit.sv
// Iterative multiply / multiply-accumulate / divide / modulo unit.
// Multiplication uses one shift-add bit per cycle and division uses one
// restoring-division bit per cycle, so every operation takes the same fixed
// latency regardless of op or operand values.
// Optional divider: define MULDIV_DIV_EN to build DIV/MOD. Without it, DIV/MOD
// still run the same number of cycles but return zero results, Flags = 3'b011.
//
//   state  | meaning
//   IDLE   | waiting for start; operands captured on the accepting edge
//   CALC   | WIDTH iterations of shift-add or restoring division
//   FINISH | results valid, done pulses for one cycle
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic                 Unsigned,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [2*WIDTH-1:0]   c,
    output logic [WIDTH-1:0]     Result,
    output logic [WIDTH-1:0]     Result2,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           Flags
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 accept;

    logic [1:0]           op_q;
    logic [WIDTH-1:0]     m_q;        // a magnitude for MUL/MLA, b magnitude for DIV/MOD
    logic [2*WIDTH-1:0]   c_q;
    logic                 neg_res_q;  // product/quotient must be negated
    logic [2*WIDTH-1:0]   prod_q;     // {hi, lo}: product accumulator or {remainder, quotient}

    logic                 a_sgn, b_sgn;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   step_d;
    logic [2*WIDTH-1:0]   mul_signed;
    logic [2*WIDTH-1:0]   fin;
    logic                 fin_dz;

`ifdef MULDIV_DIV_EN
    logic [WIDTH-1:0]     a_q;
    logic                 a_neg_q;
    logic                 dz_q;
    logic [WIDTH:0]       shifted;
    logic [WIDTH:0]       trial;
    logic                 ge;
    logic [2*WIDTH-1:0]   div_next;
    logic [WIDTH-1:0]     quo, rem;
`endif

    assign accept = (state_q == IDLE) && start;
    assign busy   = (state_q != IDLE);
    assign done   = (state_q == FINISH);

    // State and iteration counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; counter runs WIDTH-1 down to 0 during CALC
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CALC;
                    cnt_d   = CW'(WIDTH - 1);
                end
            end
            CALC: begin
                if (cnt_q == '0) state_d = FINISH;
                else             cnt_d   = cnt_q - 1'b1;
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand magnitudes and one iteration of the datapath
    always_comb begin
        a_sgn   = !Unsigned && a[WIDTH-1];
        b_sgn   = !Unsigned && b[WIDTH-1];
        a_mag   = a_sgn ? -a : a;
        b_mag   = b_sgn ? -b : b;
        mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, m_q} : '0);
        step_d  = {mul_sum, prod_q[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
        shifted  = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
        trial    = shifted - {1'b0, m_q};
        ge       = (shifted >= {1'b0, m_q});
        div_next = ge ? {trial[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1}
                      : {shifted[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
        if (op_q[1]) step_d = div_next;
`endif
    end

    // Sign correction and result selection, applied to the final iteration
    always_comb begin
        mul_signed = neg_res_q ? -step_d : step_d;
        fin        = op_q[0] ? (mul_signed + c_q) : mul_signed;
        fin_dz     = 1'b0;
`ifdef MULDIV_DIV_EN
        quo = neg_res_q ? -step_d[WIDTH-1:0] : step_d[WIDTH-1:0];
        rem = a_neg_q ? -step_d[2*WIDTH-1:WIDTH] : step_d[2*WIDTH-1:WIDTH];
        if (dz_q) begin
            quo = '1;
            rem = a_q;
        end
        if (op_q[1]) begin
            fin    = {{WIDTH{1'b0}}, (op_q[0] ? rem : quo)};
            fin_dz = dz_q;
        end
`else
        if (op_q[1]) begin
            fin    = '0;
            fin_dz = 1'b1;
        end
`endif
    end

    // Operand capture, iteration, and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q      <= '0;
            m_q       <= '0;
            c_q       <= '0;
            neg_res_q <= 1'b0;
            prod_q    <= '0;
            Result    <= '0;
            Result2   <= '0;
            Flags     <= '0;
`ifdef MULDIV_DIV_EN
            a_q       <= '0;
            a_neg_q   <= 1'b0;
            dz_q      <= 1'b0;
`endif
        end else if (accept) begin
            op_q      <= op;
            m_q       <= op[1] ? b_mag : a_mag;
            c_q       <= c;
            neg_res_q <= a_sgn ^ b_sgn;
            prod_q    <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
`ifdef MULDIV_DIV_EN
            a_q       <= a;
            a_neg_q   <= a_sgn;
            dz_q      <= (b == '0);
`endif
        end else if (state_q == CALC) begin
            prod_q <= step_d;
            if (cnt_q == '0) begin
                Result  <= fin[WIDTH-1:0];
                Result2 <= fin[2*WIDTH-1:WIDTH];
                Flags   <= {(op_q[1] ? fin[WIDTH-1] : fin[2*WIDTH-1]),
                            (fin == '0), fin_dz};
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit (WIDTH = 32).
module tb_muldiv_unit;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [1:0]     op;
    logic           Unsigned;
    logic [W-1:0]   a, b;
    logic [2*W-1:0] c;
    logic [W-1:0]   Result, Result2;
    logic           busy, done;
    logic [2:0]     Flags;

    int n_checks = 0;
    int n_pass   = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .Unsigned(Unsigned),
        .a(a), .b(b), .c(c), .Result(Result), .Result2(Result2),
        .busy(busy), .done(done), .Flags(Flags)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Issue one operation, scramble the inputs after the accepting edge, and
    // return the number of edges after acceptance at which done is sampled high.
    task automatic run_op(input logic [1:0] o, input logic u, input logic [W-1:0] aa,
                          input logic [W-1:0] bb, input logic [2*W-1:0] cc, output int lat);
        @(negedge clk);
        op = o; Unsigned = u; a = aa; b = bb; c = cc; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; op = ~o; Unsigned = ~u; a = ~aa; b = ~bb + 1'b1; c = ~cc;
        lat = 0;
        for (int k = 0; k < 4*W; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k + 1;
                break;
            end
        end
    endtask

    task automatic do_test(input string tag, input logic [1:0] o, input logic u,
                           input logic [W-1:0] aa, input logic [W-1:0] bb,
                           input logic [2*W-1:0] cc, input logic [63:0] exp_res,
                           input logic [2:0] exp_flags);
        int lat;
        run_op(o, u, aa, bb, cc, lat);
        check_val({tag, "/latency"}, 64'(lat), 64'(W + 1));
        check_val({tag, "/result"}, {Result2, Result}, exp_res);
        check_val({tag, "/flags"}, 64'(Flags), 64'(exp_flags));
    endtask

    initial begin
        int n_done;
        logic [63:0] cap;

        reset = 1'b1; start = 1'b0; op = 2'b00; Unsigned = 1'b1;
        a = '0; b = '0; c = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_val("reset/result", {Result2, Result}, 64'h0);
        check_val("reset/ctl", {59'h0, busy, done, Flags}, 64'h0);

        do_test("mul_ff", 2'b00, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0,
                64'hFFFF_FFFE_0000_0001, 3'b100);
        do_test("mul_neg", 2'b00, 1'b0, 32'hFFFF_FFFD, 32'd7, 64'h0,
                64'hFFFF_FFFF_FFFF_FFEB, 3'b100);
        do_test("mla_small", 2'b01, 1'b0, 32'd2, 32'd3, 64'd1, 64'd7, 3'b000);
        do_test("mla_zero", 2'b01, 1'b0, 32'hFFFF_FFFF, 32'd1, 64'd1, 64'h0, 3'b010);
        do_test("mul_zero", 2'b00, 1'b1, 32'd0, 32'd5, 64'h0, 64'h0, 3'b010);
        do_test("mul_carry", 2'b00, 1'b1, 32'h0001_0000, 32'h0001_0000, 64'h0,
                64'h0000_0001_0000_0000, 3'b000);
        do_test("mla_wrap", 2'b01, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                64'h0000_0001_FFFF_FFFF, 64'h0000_0000_0000_0000, 3'b010);
`ifdef MULDIV_DIV_EN
        do_test("div_neg", 2'b10, 1'b0, 32'hFFFF_FFF9, 32'd2, 64'h0,
                64'h0000_0000_FFFF_FFFD, 3'b100);
        do_test("mod_neg", 2'b11, 1'b0, 32'hFFFF_FFF9, 32'd2, 64'h0,
                64'h0000_0000_FFFF_FFFF, 3'b100);
        do_test("div_ovf", 2'b10, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0,
                64'h0000_0000_8000_0000, 3'b100);
        do_test("mod_ovf", 2'b11, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0,
                64'h0, 3'b010);
        do_test("div_by0", 2'b10, 1'b1, 32'd10, 32'd0, 64'h0,
                64'h0000_0000_FFFF_FFFF, 3'b101);
        do_test("mod_by0", 2'b11, 1'b1, 32'd10, 32'd0, 64'h0, 64'd10, 3'b001);
        do_test("div_u", 2'b10, 1'b1, 32'd100, 32'd7, 64'h0, 64'd14, 3'b000);
        do_test("mod_u", 2'b11, 1'b1, 32'd100, 32'd7, 64'h0, 64'd2, 3'b000);
        do_test("mod_sgn_b", 2'b11, 1'b0, 32'd7, 32'hFFFF_FFFE, 64'h0, 64'd1, 3'b000);
`else
        do_test("div_off", 2'b10, 1'b0, 32'hFFFF_FFF9, 32'd2, 64'h0, 64'h0, 3'b011);
        do_test("mod_off", 2'b11, 1'b1, 32'd10, 32'd0, 64'h0, 64'h0, 3'b011);
`endif

        // start re-pulsed while busy must be ignored
        @(negedge clk);
        op = 2'b00; Unsigned = 1'b1; a = 32'd6; b = 32'd7; c = '0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        check_val("repulse/busy", 64'(busy), 64'd1);
        a = 32'd100; b = 32'd100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_done = 0;
        cap = '0;
        for (int k = 0; k < 3*W; k++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                cap = {Result2, Result};
            end
        end
        check_val("repulse/ndone", 64'(n_done), 64'd1);
        check_val("repulse/result", cap, 64'd42);

        // reset in the middle of CALC aborts with no done pulse
        @(negedge clk);
        op = 2'b00; Unsigned = 1'b1; a = 32'd5; b = 32'd5; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_val("abort/result", {Result2, Result}, 64'h0);
        check_val("abort/ctl", {59'h0, busy, done, Flags}, 64'h0);
        n_done = 0;
        for (int k = 0; k < W + 5; k++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check_val("abort/ndone", 64'(n_done), 64'd0);
        do_test("after_abort", 2'b00, 1'b1, 32'd9, 32'd9, 64'h0, 64'd81, 3'b000);

        // reset wins over a simultaneous start
        @(negedge clk);
        reset = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        check_val("rst_vs_start/busy", 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
